stack_unit: RTL and testbench

STACK_UNIT -- requirements
Module: stack_unit

---
 rtl/stack_pkg.sv | 32 +++
 rtl/stack_mem.sv | 27 ++
 rtl/stack_unit.sv | 123 ++++++++++++
 tb/tb_stack_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants and command decoding for the stack unit.
package stack_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Push source select encoding for MtoS
    localparam logic SRC_MEM = 1'b1;
    localparam logic SRC_ALU = 1'b0;

    typedef enum logic [2:0] {
        OpNone,
        OpPush,
        OpPop,
        OpTos,
        OpIllegal
    } op_e;

    // Any combination of more than one strobe is illegal
    function automatic op_e decode_op(input logic p_push, input logic p_pop, input logic p_tos);
        op_e res;
        case ({p_push, p_pop, p_tos})
            3'b000:  res = OpNone;
            3'b100:  res = OpPush;
            3'b010:  res = OpPop;
            3'b001:  res = OpTos;
            default: res = OpIllegal;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_mem
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with registered read data and sticky error flags.
module stack_unit
    import stack_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   tos,
    input  logic                   MtoS,
    input  logic [WIDTH-1:0]       mem_data,
    input  logic [WIDTH-1:0]       alu_res,
    input  logic                   clr_err,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   ovf,
    output logic                   udf,
    output logic                   cmd_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [CW-1:0]    sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d, udf_q, udf_d, err_q, err_d;
    logic             ovf_set, udf_set, err_set;
    logic             do_write, wr_en;
    logic [WIDTH-1:0] push_data, rd_data;
    logic [AW-1:0]    waddr, raddr;
    op_e              op;

    assign op        = decode_op(push, pop, tos);
    assign push_data = (MtoS == SRC_MEM) ? mem_data : alu_res;
    assign empty     = (sp_q == '0);
    assign full      = (sp_q == CW'(DEPTH));
    assign waddr     = sp_q[AW-1:0];
    assign raddr     = sp_q[AW-1:0] - AW'(1);
    // A write must never land on an edge where reset is asserted
    assign wr_en     = do_write & ~rst;

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (raddr),
        .rdata (rd_data)
    );

    // Next-state for pointer, read data and flags from the decoded command
    always_comb begin
        sp_d     = sp_q;
        dout_d   = dout_q;
        do_write = 1'b0;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        err_set  = 1'b0;
        case (op)
            OpPush: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    do_write = 1'b1;
                    sp_d     = sp_q + CW'(1);
                end
            end
            OpPop: begin
                if (empty) begin
                    udf_set = 1'b1;
                end else begin
                    dout_d = rd_data;
                    sp_d   = sp_q - CW'(1);
                end
            end
            OpTos: begin
                if (empty) begin
                    udf_set = 1'b1;
                end else begin
                    dout_d = rd_data;
                end
            end
            OpIllegal: err_set = 1'b1;
            default: ;
        endcase
        // Setting a flag takes priority over clearing it
        ovf_d = ovf_set | (ovf_q & ~clr_err);
        udf_d = udf_set | (udf_q & ~clr_err);
        err_d = err_set | (err_q & ~clr_err);
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
            err_q  <= err_d;
        end
    end

    assign dout    = dout_q;
    assign count   = sp_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_stack_unit;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       push = 1'b0, pop = 1'b0, tos = 1'b0, mtos = 1'b0, clr_err = 1'b0;
    logic [7:0] mem_data = 8'h00, alu_res = 8'h00;
    logic [7:0] dout;
    logic [3:0] count;
    logic       empty, full, ovf, udf, cmd_err;

    int total = 0;
    int bad   = 0;

    // Reference model: queue back is the top of stack
    logic [7:0] m_q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf = 1'b0, m_udf = 1'b0, m_err = 1'b0;

    stack_unit #(
        .WIDTH (8),
        .DEPTH (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .tos      (tos),
        .MtoS     (mtos),
        .mem_data (mem_data),
        .alu_res  (alu_res),
        .clr_err  (clr_err),
        .dout     (dout),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .udf      (udf),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    function automatic void model_reset();
        m_q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_err  = 1'b0;
    endfunction

    // Drive one cycle of stimulus, then advance the model by the same command
    task automatic step(input logic p, input logic po, input logic t, input logic m,
                        input logic [7:0] md, input logic [7:0] ar, input logic c);
        logic so, su, se;
        push = p; pop = po; tos = t; mtos = m; mem_data = md; alu_res = ar; clr_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
        so = 1'b0; su = 1'b0; se = 1'b0;
        if (int'(p) + int'(po) + int'(t) > 1) begin
            se = 1'b1;
        end else if (p) begin
            if (m_q.size() == D) so = 1'b1;
            else m_q.push_back(m ? md : ar);
        end else if (po) begin
            if (m_q.size() == 0) su = 1'b1;
            else m_dout = m_q.pop_back();
        end else if (t) begin
            if (m_q.size() == 0) su = 1'b1;
            else m_dout = m_q[$];
        end
        m_ovf = so | (m_ovf & ~c);
        m_udf = su | (m_udf & ~c);
        m_err = se | (m_err & ~c);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        total++;
        if ({dout, count, empty, full, ovf, udf, cmd_err} !== {8'h00, 4'd0, 5'b10000}) begin
            bad++;
            $display("FAIL reset_state: got dout=%h count=%0d e/f/o/u/c=%b%b%b%b%b want 00 0 10000",
                     dout, count, empty, full, ovf, udf, cmd_err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic();
        step(1, 0, 0, 1, 8'h11, 8'h77, 0);
        step(1, 0, 0, 0, 8'h99, 8'h22, 0);
        step(0, 0, 1, 0, 8'h00, 8'h00, 0);
        total++;
        if (dout !== 8'h22 || count !== 4'd2) begin
            bad++;
            $display("FAIL basic_tos: got dout=%h count=%0d want 22 2", dout, count);
        end
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
        total++;
        if (dout !== 8'h22 || count !== 4'd1) begin
            bad++;
            $display("FAIL basic_pop1: got dout=%h count=%0d want 22 1", dout, count);
        end
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
        total++;
        if (dout !== 8'h11 || count !== 4'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL basic_pop2: got dout=%h count=%0d empty=%b want 11 0 1",
                     dout, count, empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 8; i++) step(1, 0, 0, 1, 8'(i), 8'h00, 0);
        total++;
        if (full !== 1'b1 || ovf !== 1'b0 || count !== 4'd8) begin
            bad++;
            $display("FAIL fill: got full=%b ovf=%b count=%0d want 1 0 8", full, ovf, count);
        end
        step(1, 0, 0, 1, 8'hFF, 8'h00, 0);
        total++;
        if (full !== 1'b1 || ovf !== 1'b1 || count !== 4'd8) begin
            bad++;
            $display("FAIL overflow: got full=%b ovf=%b count=%0d want 1 1 8", full, ovf, count);
        end
        for (int i = 8; i >= 1; i--) begin
            step(0, 1, 0, 0, 8'h00, 8'h00, 0);
            total++;
            if (dout !== 8'(i) || count !== 4'(i - 1)) begin
                bad++;
                $display("FAIL drain_%0d: got dout=%h count=%0d want %h %0d",
                         i, dout, count, 8'(i), i - 1);
            end
        end
        step(0, 0, 0, 0, 8'h00, 8'h00, 1);
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: got ovf=%b want 0", ovf);
        end
    endtask

    task automatic test_underflow();
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
        total++;
        if (udf !== 1'b1 || dout !== 8'h01 || count !== 4'd0) begin
            bad++;
            $display("FAIL underflow: got udf=%b dout=%h count=%0d want 1 01 0", udf, dout, count);
        end
        step(0, 0, 0, 0, 8'h00, 8'h00, 1);
        total++;
        if (udf !== 1'b0) begin
            bad++;
            $display("FAIL udf_clear: got udf=%b want 0", udf);
        end
    endtask

    task automatic test_cmd_err();
        step(1, 0, 0, 0, 8'h00, 8'h31, 0);
        step(1, 0, 0, 0, 8'h00, 8'h32, 0);
        step(1, 0, 0, 0, 8'h00, 8'h33, 0);
        step(1, 1, 0, 0, 8'h00, 8'h44, 0);
        total++;
        if (count !== 4'd3 || dout !== 8'h01 || cmd_err !== 1'b1) begin
            bad++;
            $display("FAIL push_pop: got count=%0d dout=%h cmd_err=%b want 3 01 1",
                     count, dout, cmd_err);
        end
        step(1, 0, 1, 0, 8'h00, 8'h55, 1);
        total++;
        if (cmd_err !== 1'b1 || count !== 4'd3) begin
            bad++;
            $display("FAIL set_wins: got cmd_err=%b count=%0d want 1 3", cmd_err, count);
        end
        step(0, 0, 0, 0, 8'h00, 8'h00, 1);
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
        total++;
        if (cmd_err !== 1'b0 || dout !== 8'h33 || count !== 4'd2) begin
            bad++;
            $display("FAIL err_clear_pop: got cmd_err=%b dout=%h count=%0d want 0 33 2",
                     cmd_err, dout, count);
        end
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_overwrite();
        step(1, 0, 0, 1, 8'hAA, 8'h00, 0);
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
        step(1, 0, 0, 1, 8'hBB, 8'h00, 0);
        total++;
        if (dout !== 8'hAA) begin
            bad++;
            $display("FAIL popped_hold: got dout=%h want aa", dout);
        end
        step(0, 0, 1, 0, 8'h00, 8'h00, 0);
        total++;
        if (dout !== 8'hBB || count !== 4'd1) begin
            bad++;
            $display("FAIL overwrite: got dout=%h count=%0d want bb 1", dout, count);
        end
        step(0, 1, 0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'h00, 8'(8'hC0 + i), 0);
        step(0, 0, 1, 0, 8'h00, 8'h00, 0);
        step(1, 0, 1, 0, 8'h00, 8'h00, 0);
        total++;
        if (count !== 4'd5 || dout !== 8'hC4 || cmd_err !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: got count=%0d dout=%h cmd_err=%b want 5 c4 1",
                     count, dout, cmd_err);
        end
        #3;
        rst = 1'b1; push = 1'b1; mtos = 1'b1; mem_data = 8'h5A;
        #1;
        total++;
        if ({dout, count, empty, full, ovf, udf, cmd_err} !== {8'h00, 4'd0, 5'b10000}) begin
            bad++;
            $display("FAIL async_reset: got dout=%h count=%0d e/f/o/u/c=%b%b%b%b%b want 00 0 10000",
                     dout, count, empty, full, ovf, udf, cmd_err);
        end
        @(posedge clk);
        #1;
        total++;
        if (count !== 4'd0 || empty !== 1'b1) begin
            bad++;
            $display("FAIL push_in_reset: got count=%0d empty=%b want 0 1", count, empty);
        end
        push = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        int r;
        logic [16:0] exp, got;
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 15);
            step(r < 6, (r >= 6 && r < 9) || r == 12, r == 9 || r == 13, 1'($urandom),
                 8'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
            exp = {m_dout, 4'(m_q.size()), m_q.size() == 0, m_q.size() == D, m_ovf, m_udf, m_err};
            got = {dout, count, empty, full, ovf, udf, cmd_err};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_%0d: got {dout,count,e,f,o,u,c}=%h want %h", n, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_underflow();
        test_cmd_err();
        test_overwrite();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
